// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM state encodings and completion codes.
// Imported by the controller and by anything that decodes haltCode.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RST_HOLD = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_HALT    = 2'd1,
        HC_ERROR   = 2'd2,
        HC_TIMEOUT = 2'd3
    } halt_code_e;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int unsigned ctrWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones instead of wrapping.
module run_ctrl_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Run-control and monitor: sequences CPU reset release, gates the CPU clock and reports why a run ended.
// Optional single-instruction stepping is compiled in when RUN_CTRL_STEP_EN is defined.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned           OPCODE_W    = 7,
    parameter logic [OPCODE_W-1:0]   HALT_OPCODE = {OPCODE_W{1'b1}},
    parameter int unsigned           ERR_W       = 2,
    parameter int unsigned           CNT_W       = 64,
    parameter int unsigned           RST_CYCLES  = 4,
    parameter int unsigned           MAX_CYCLES  = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [ERR_W-1:0]    cpuError,
`ifdef RUN_CTRL_STEP_EN
    input  logic                stepMode,
    input  logic                stepPulse,
    input  logic                atFetch,
`endif
    output logic                cpuNotReset,
    output logic                cpuClockEn,
    output logic [CNT_W-1:0]    tickCount,
    output logic                done,
    output logic [1:0]          haltCode,
    output logic [ERR_W-1:0]    errorLatched
);

    localparam int unsigned      RC_W       = ctrWidth(RST_CYCLES);
    localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LIMIT = CNT_W'(MAX_CYCLES);
    localparam bit               WDOG_EN    = (MAX_CYCLES != 0);

    state_e            state_q, state_d;
    logic [RC_W-1:0]   rstCnt_q, rstCnt_d;
    halt_code_e        haltCode_q, haltCode_d;
    logic [ERR_W-1:0]  errorLatched_q, errorLatched_d;

    logic checkEn;
    logic termHalt;
    logic termError;
    logic termTimeout;
    logic terminate;
    logic startRun;
    logic stepGate;
    logic clockEn;

    // The first RUN cycle is masked: opcode/error still reflect the CPU's reset state.
    always_comb begin
        checkEn     = (state_q == ST_RUN) && (tickCount != '0);
        termHalt    = checkEn && (opcode == HALT_OPCODE);
        termError   = checkEn && (cpuError != '0);
        termTimeout = checkEn && WDOG_EN && (tickCount == TICK_LIMIT);
        terminate   = termHalt || termError || termTimeout;
        startRun    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        clockEn     = (state_q == ST_RUN) && !terminate && stepGate;
    end

`ifdef RUN_CTRL_STEP_EN
    logic stepActive_q, stepActive_d;
    logic stepTicked_q, stepTicked_d;

    // A step opens on stepPulse and closes at the first fetch after at least one enabled tick.
    always_comb begin
        stepActive_d = stepActive_q;
        stepTicked_d = stepTicked_q;
        stepGate     = 1'b1;
        if ((state_q != ST_RUN) || !stepMode) begin
            stepActive_d = 1'b0;
            stepTicked_d = 1'b0;
        end else if (!stepActive_q) begin
            stepGate = 1'b0;
            if (stepPulse) begin
                stepActive_d = 1'b1;
                stepTicked_d = 1'b0;
            end
        end else if (stepTicked_q && atFetch) begin
            stepGate     = 1'b0;
            stepActive_d = 1'b0;
            stepTicked_d = 1'b0;
        end else if (!terminate) begin
            stepTicked_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stepActive_q <= 1'b0;
            stepTicked_q <= 1'b0;
        end else begin
            stepActive_q <= stepActive_d;
            stepTicked_q <= stepTicked_d;
        end
    end
`else
    assign stepGate = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        rstCnt_d       = rstCnt_q;
        haltCode_d     = haltCode_q;
        errorLatched_d = errorLatched_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d        = ST_RST_HOLD;
                    rstCnt_d       = '0;
                    haltCode_d     = HC_NONE;
                    errorLatched_d = '0;
                end
            end
            ST_RST_HOLD: begin
                if (rstCnt_q == RC_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rstCnt_d = rstCnt_q + RC_W'(1);
                end
            end
            ST_RUN: begin
                if (termHalt) begin
                    haltCode_d = HC_HALT;
                end else if (termError) begin
                    haltCode_d     = HC_ERROR;
                    errorLatched_d = cpuError;
                end else if (termTimeout) begin
                    haltCode_d = HC_TIMEOUT;
                end
                if (terminate) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rstCnt_q       <= '0;
            haltCode_q     <= HC_NONE;
            errorLatched_q <= '0;
        end else begin
            state_q        <= state_d;
            rstCnt_q       <= rstCnt_d;
            haltCode_q     <= haltCode_d;
            errorLatched_q <= errorLatched_d;
        end
    end

    run_ctrl_sat_counter #(
        .WIDTH (CNT_W)
    ) u_tickCounter (
        .clock  (clock),
        .reset  (reset),
        .clear  (startRun),
        .enable (clockEn),
        .count  (tickCount)
    );

    assign cpuNotReset  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign cpuClockEn   = clockEn;
    assign done         = (state_q == ST_DONE);
    assign haltCode     = haltCode_q;
    assign errorLatched = errorLatched_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: reset release, halt/error/timeout termination, saturation,
// restart and mid-run reset; stepping is exercised when RUN_CTRL_STEP_EN is defined.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0]  code;
        logic [63:0] ticks;
        logic [1:0]  err;
    } exp_t;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        startWd  = 1'b0;
    logic        startSat = 1'b0;
    logic [6:0]  opcode   = 7'h00;
    logic [1:0]  cpuError = 2'b00;

    logic        cpuNotReset, cpuClockEn, done;
    logic [63:0] tickCount;
    logic [1:0]  haltCode, errorLatched;

    logic        cpuNotResetWd, cpuClockEnWd, doneWd;
    logic [63:0] tickCountWd;
    logic [1:0]  haltCodeWd, errorLatchedWd;

    logic        cpuNotResetSat, cpuClockEnSat, doneSat;
    logic [3:0]  tickCountSat;
    logic [1:0]  haltCodeSat, errorLatchedSat;

`ifdef RUN_CTRL_STEP_EN
    logic stepMode  = 1'b0;
    logic stepPulse = 1'b0;
    logic atFetch;
    assign atFetch = (tickCount != 64'd0) && ((tickCount % 64'd3) == 64'd0);
`endif

    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t sbQ[$];
    exp_t sbWdQ[$];

    always #5 clock = ~clock;

    run_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode), .cpuError(cpuError),
`ifdef RUN_CTRL_STEP_EN
        .stepMode(stepMode), .stepPulse(stepPulse), .atFetch(atFetch),
`endif
        .cpuNotReset(cpuNotReset), .cpuClockEn(cpuClockEn), .tickCount(tickCount),
        .done(done), .haltCode(haltCode), .errorLatched(errorLatched)
    );

    run_ctrl #(.MAX_CYCLES(100)) dutWd (
        .clock(clock), .reset(reset), .start(startWd), .opcode(opcode), .cpuError(cpuError),
`ifdef RUN_CTRL_STEP_EN
        .stepMode(1'b0), .stepPulse(1'b0), .atFetch(1'b0),
`endif
        .cpuNotReset(cpuNotResetWd), .cpuClockEn(cpuClockEnWd), .tickCount(tickCountWd),
        .done(doneWd), .haltCode(haltCodeWd), .errorLatched(errorLatchedWd)
    );

    run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) dutSat (
        .clock(clock), .reset(reset), .start(startSat), .opcode(opcode), .cpuError(cpuError),
`ifdef RUN_CTRL_STEP_EN
        .stepMode(1'b0), .stepPulse(1'b0), .atFetch(1'b0),
`endif
        .cpuNotReset(cpuNotResetSat), .cpuClockEn(cpuClockEnSat), .tickCount(tickCountSat),
        .done(doneSat), .haltCode(haltCodeSat), .errorLatched(errorLatchedSat)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset;
        reset    = 1'b1;
        start    = 1'b0;
        startWd  = 1'b0;
        startSat = 1'b0;
        opcode   = 7'h00;
        cpuError = 2'b00;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic pulseStart;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic waitRun;
        int budget = 0;
        while (!cpuNotReset && budget < 20) begin
            tick;
            budget++;
        end
        if (!cpuNotReset) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL wait_run: cpuNotReset=%0b, required 1 within 20 cycles", cpuNotReset);
        end
    endtask

    task automatic advanceTo(input logic [63:0] n);
        int budget = 0;
        while (tickCount != n && budget < 200) begin
            tick;
            budget++;
        end
        if (tickCount != n) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL advance_to: tickCount=%0d, required %0d", tickCount, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        testsRun++;
        if ({cpuNotReset, cpuClockEn, done, haltCode, errorLatched} !== 7'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: {nr,en,done,code,err}=%b, required 0000000",
                     {cpuNotReset, cpuClockEn, done, haltCode, errorLatched});
        end
        testsRun++;
        if (tickCount !== 64'd0 || tickCountWd !== 64'd0 || tickCountSat !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ticks: %0d/%0d/%0d, required 0/0/0", tickCount, tickCountWd, tickCountSat);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_release;
        int  lowCycles = 0;
        bit  enDuringHold = 1'b0;
        applyReset;
        tick;
        pulseStart;
        while (!cpuNotReset && lowCycles < 10) begin
            if (cpuClockEn) enDuringHold = 1'b1;
            lowCycles++;
            tick;
        end
        testsRun++;
        if (lowCycles != 4 || enDuringHold) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: low for %0d cycles (clockEn seen=%0b), required 4 (0)", lowCycles, enDuringHold);
        end
        testsRun++;
        if (cpuClockEn !== 1'b1 || tickCount !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL run_entry: clockEn=%0b tickCount=%0d, required 1 and 0", cpuClockEn, tickCount);
        end
        for (int k = 1; k <= 3; k++) begin
            tick;
            testsRun++;
            if (tickCount !== 64'(k)) begin
                testsFailed++;
                $display("[TB] FAIL tick_count: tickCount=%0d, required %0d", tickCount, k);
            end
        end
    endtask

    task automatic test_halt;
        exp_t e;
        applyReset;
        tick;
        pulseStart;
        waitRun;
        opcode = 7'h7F;
        #1;
        testsRun++;
        if (cpuClockEn !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL halt_mask_first: clockEn=%0b, required 1", cpuClockEn);
        end
        tick;
        opcode = 7'h00;
        testsRun++;
        if (tickCount !== 64'd1 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL halt_mask_tick: tickCount=%0d done=%0b, required 1 and 0", tickCount, done);
        end
        advanceTo(64'd10);
        opcode = 7'h7F;
        sbQ.push_back('{code: HC_HALT, ticks: 64'd10, err: 2'b00});
        #1;
        testsRun++;
        if (cpuClockEn !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL halt_gate: clockEn=%0b, required 0", cpuClockEn);
        end
        tick;
        opcode = 7'h00;
        testsRun++;
        if (done !== 1'b1 || sbQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL halt_done: done=%0b, required 1", done);
        end else begin
            e = sbQ.pop_front();
            if ({haltCode, tickCount, errorLatched} !== {e.code, e.ticks, e.err}) begin
                testsFailed++;
                $display("[TB] FAIL halt_result: code=%0d ticks=%0d err=%0d, required %0d %0d %0d",
                         haltCode, tickCount, errorLatched, e.code, e.ticks, e.err);
            end
        end
        repeat (3) tick;
        testsRun++;
        if (done !== 1'b1 || tickCount !== 64'd10 || cpuClockEn !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL done_frozen: done=%0b ticks=%0d en=%0b, required 1 10 0", done, tickCount, cpuClockEn);
        end
    endtask

    task automatic test_priority;
        exp_t e;
        pulseStart;
        testsRun++;
        if (tickCount !== 64'd0 || haltCode !== 2'd0 || done !== 1'b0 || cpuNotReset !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL restart_clear: ticks=%0d code=%0d done=%0b nr=%0b, required 0 0 0 0",
                     tickCount, haltCode, done, cpuNotReset);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) pulseStart;
            waitRun;
            advanceTo(64'd5);
            cpuError = 2'b01;
            if (pass == 0) begin
                opcode = 7'h7F;
                sbQ.push_back('{code: HC_HALT, ticks: 64'd5, err: 2'b00});
            end else begin
                sbQ.push_back('{code: HC_ERROR, ticks: 64'd5, err: 2'b01});
            end
            tick;
            opcode   = 7'h00;
            cpuError = 2'b00;
            testsRun++;
            if (done !== 1'b1 || sbQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL prio_done pass %0d: done=%0b, required 1", pass, done);
            end else begin
                e = sbQ.pop_front();
                if ({haltCode, tickCount, errorLatched} !== {e.code, e.ticks, e.err}) begin
                    testsFailed++;
                    $display("[TB] FAIL prio_result pass %0d: code=%0d ticks=%0d err=%0d, required %0d %0d %0d",
                             pass, haltCode, tickCount, errorLatched, e.code, e.ticks, e.err);
                end
            end
        end
    endtask

    task automatic test_watchdog_saturation;
        exp_t e;
        int   cyc = 0;
        startWd  = 1'b1;
        startSat = 1'b1;
        sbWdQ.push_back('{code: HC_TIMEOUT, ticks: 64'd100, err: 2'b00});
        tick;
        startWd  = 1'b0;
        startSat = 1'b0;
        while (!doneWd && cyc < 300) begin
            tick;
            cyc++;
        end
        testsRun++;
        if (doneWd !== 1'b1 || sbWdQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL wdog_done: done=%0b after %0d cycles, required 1", doneWd, cyc);
        end else begin
            e = sbWdQ.pop_front();
            if ({haltCodeWd, tickCountWd, errorLatchedWd, cpuClockEnWd} !== {e.code, e.ticks, e.err, 1'b0}) begin
                testsFailed++;
                $display("[TB] FAIL wdog_result: code=%0d ticks=%0d err=%0d en=%0b, required %0d %0d %0d 0",
                         haltCodeWd, tickCountWd, errorLatchedWd, cpuClockEnWd, e.code, e.ticks, e.err);
            end
        end
        testsRun++;
        if (tickCountSat !== 4'hF || doneSat !== 1'b0 || cpuClockEnSat !== 1'b1 ||
            cpuNotResetSat !== 1'b1 || haltCodeSat !== 2'd0 || errorLatchedSat !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL saturate: ticks=%0d done=%0b en=%0b nr=%0b code=%0d err=%0d, required 15 0 1 1 0 0",
                     tickCountSat, doneSat, cpuClockEnSat, cpuNotResetSat, haltCodeSat, errorLatchedSat);
        end
    endtask

    task automatic test_mid_reset;
        pulseStart;
        testsRun++;
        if (errorLatched !== 2'd0 || haltCode !== 2'd0 || tickCount !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL restart_after_error: err=%0d code=%0d ticks=%0d, required 0 0 0",
                     errorLatched, haltCode, tickCount);
        end
        waitRun;
        advanceTo(64'd4);
        start = 1'b1;
        tick;
        start = 1'b0;
        testsRun++;
        if (tickCount !== 64'd5 || cpuNotReset !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL start_in_run: ticks=%0d nr=%0b, required 5 1", tickCount, cpuNotReset);
        end
        advanceTo(64'd7);
        reset = 1'b1;
        start = 1'b1;
        tick;
        reset = 1'b0;
        start = 1'b0;
        testsRun++;
        if ({cpuNotReset, cpuClockEn, done, haltCode, errorLatched} !== 7'b0 || tickCount !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset: {nr,en,done,code,err}=%b ticks=%0d, required 0000000 0",
                     {cpuNotReset, cpuClockEn, done, haltCode, errorLatched}, tickCount);
        end
    endtask

`ifdef RUN_CTRL_STEP_EN
    task automatic test_step;
        int cyc;
        applyReset;
        stepMode = 1'b1;
        tick;
        pulseStart;
        waitRun;
        repeat (3) tick;
        testsRun++;
        if (cpuClockEn !== 1'b0 || tickCount !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL step_idle: en=%0b ticks=%0d, required 0 0", cpuClockEn, tickCount);
        end
        for (int s = 1; s <= 3; s++) begin
            stepPulse = 1'b1;
            tick;
            stepPulse = 1'b0;
            cyc = 0;
            while (cpuClockEn && cyc < 30) begin
                tick;
                cyc++;
            end
            repeat (2) tick;
            testsRun++;
            if (tickCount !== 64'(3 * s) || cpuClockEn !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL step_%0d: ticks=%0d en=%0b, required %0d 0", s, tickCount, cpuClockEn, 3 * s);
            end
        end
        stepMode = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset;
        test_reset_release;
        test_halt;
        test_priority;
        test_watchdog_saturation;
        test_mid_reset;
`ifdef RUN_CTRL_STEP_EN
        test_step;
`endif
        testsRun++;
        if (sbQ.size() != 0 || sbWdQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", sbQ.size(), sbWdQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Synthesizable run-control and monitor block for the CPU.
- Sequences CPU reset release and gates the CPU clock enable.
- Counts executed ticks and watches for halt, error and timeout; freezes the CPU and reports a completion code.
- Replaces testbench-only halt/error/watchdog logic so the same control works in simulation and on FPGA, and supports restarting without a global reset.

Parameters:
OPCODE_W, 7, width of instruction-register opcode
HALT_OPCODE, 7'b1111111, opcode value meaning halt
ERR_W, 2, width of CPU error code
CNT_W, 64, tick counter width
RST_CYCLES, 4, cycles cpuNotReset held low after start (min 1)
MAX_CYCLES, 0, watchdog limit in ticks; 0 disables watchdog

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: begin a run
opcode  in  OPCODE_W  CPU current opcode (irOpcode)
cpuError  in  ERR_W  CPU error code, nonzero = fault
cpuNotReset  out  1  drives CPU notReset
cpuClockEn  out  1  CPU clock enable
tickCount  out  CNT_W  ticks executed in current run
done  out  1  run finished, held until next start
haltCode  out  2  0 none, 1 halt, 2 error, 3 timeout
errorLatched  out  ERR_W  cpuError value captured at termination

Behaviour:
- Reset: state IDLE; cpuNotReset=0, cpuClockEn=0, tickCount=0, done=0, haltCode=0, errorLatched=0. Reset wins over every other input on the same edge, including mid-run.
- States:
  - IDLE: waits for start; start -> RST_HOLD, rstCnt=0.
  - RST_HOLD: cpuNotReset=0, cpuClockEn=0; rstCnt increments; at rstCnt==RST_CYCLES-1 -> RUN.
  - RUN: cpuNotReset=1; cpuClockEn=1 unless a terminating condition is true this cycle. cpuClockEn is combinational from state and inputs so the terminating instruction never gets another CPU edge.
  - DONE: cpuNotReset=1, cpuClockEn=0, done=1; outputs frozen.
- Entering RST_HOLD from IDLE or DONE clears tickCount, haltCode, errorLatched and done.
- Termination is evaluated only in RUN with tickCount!=0; the first RUN cycle is masked so the opcode/error left by reset is ignored. Priority:
  - halt: opcode==HALT_OPCODE -> haltCode=1.
  - error: cpuError!=0 -> haltCode=2, errorLatched=cpuError.
  - timeout: MAX_CYCLES!=0 and tickCount==MAX_CYCLES -> haltCode=3.
  - Any termination -> DONE on the next edge.
- tickCount increments by 1 on every edge where state==RUN and cpuClockEn=1. It saturates at all-ones and never wraps.
- start in RST_HOLD or RUN is ignored. start in DONE restarts the run.
- MAX_CYCLES is compared zero-extended to CNT_W.

Optional Feature:
RUN_CTRL_STEP_EN
- With: adds inputs stepMode (1) and stepPulse (1) and input atFetch (1, microsequencer at fetch address).
  - In RUN with stepMode=1, cpuClockEn is low until stepPulse.
  - After stepPulse it stays high until the first cycle atFetch=1 following at least one enabled tick, i.e. one instruction executes.
  - Termination checks still apply. tickCount counts only enabled ticks.
  - stepPulse while already stepping is ignored.
- Without: no extra ports; RUN free-runs as described above.

Decomposition:
- Shared definitions header (run-ctrl-defs.v): state encodings IDLE/RST_HOLD/RUN/DONE and haltCode constants NONE/HALT/ERROR/TIMEOUT, also used by the testbench top and monitors.
- One natural sub-module: sat_counter (parametrised width, sync clear, enable, saturating increment), used for tickCount.

Test Plan:
- reset, start at cycle 2, RST_CYCLES=4 -> cpuNotReset low for exactly 4 cycles, then high; cpuClockEn rises with it; tickCount counts 1,2,3...
- opcode=7'h7F on the first RUN cycle, then at tick 10 -> first occurrence ignored; at tick 10 cpuClockEn drops same cycle, next edge done=1, haltCode=1, tickCount=10.
- cpuError=2'b01 and opcode=HALT together at tick 5 -> haltCode=1 (halt priority), errorLatched=0; repeat with error only -> haltCode=2, errorLatched=1.
- MAX_CYCLES=100, opcode never halts -> done at tickCount=100, haltCode=3; MAX_CYCLES=0, CNT_W=4 -> tickCount saturates at 15, no done.
- reset asserted mid-RUN at tick 7 -> all outputs return to reset values next edge; start in DONE -> tickCount=0, haltCode=0, new RST_HOLD.
- STEP_EN: stepMode=1, three stepPulses, atFetch every 3 ticks -> exactly 3 instructions, tickCount=9, cpuClockEn low between steps.
